// File: rtl/fft_pkg.sv
// Shared defaults, read-side state type and the index bit-reversal helper for the
// FFT output reorder buffer.
package fft_pkg;

  localparam int unsigned WidthDef = 16;
  localparam int unsigned NDef     = 9;

  typedef enum logic {StIdle, StRead} rd_state_e;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) r[5'(i)] = v[5'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_if.sv
// Sample stream into the reorder buffer (bit-reversed order) and bin stream out of it
// (natural order).
interface fft_reorder_if
  import fft_pkg::*;
#(
  parameter int unsigned width = WidthDef,
  parameter int unsigned N     = NDef
);
  logic                    en_in;
  logic [N-1:0]            cnt_in;
  logic signed [width-1:0] xin_re;
  logic signed [width-1:0] xin_im;
  logic                    en_out;
  logic [N-1:0]            cnt_out;
  logic signed [width-1:0] yout_re;
  logic signed [width-1:0] yout_im;

  modport master (
    output en_in, cnt_in, xin_re, xin_im,
    input  en_out, cnt_out, yout_re, yout_im
  );

  modport slave (
    input  en_in, cnt_in, xin_re, xin_im,
    output en_out, cnt_out, yout_re, yout_im
  );
endinterface

// File: rtl/reorder_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the address MSB selects the bank.
// Read data is registered, so it appears one cycle after the read is issued.
module reorder_ram #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [2**AddrW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder.sv
// Converts the bit-reversed sample stream of a pipelined FFT into natural bin order
// using two ping-pong banks; a completed bank is streamed out while the other fills.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int unsigned width = WidthDef,
  parameter int unsigned N     = NDef
) (
  input  logic         clk,
  input  logic         areset,
  fft_reorder_if.slave bus,
  output logic         ovf
);

  typedef logic [N-1:0] cnt_t;
  localparam cnt_t CntLast = '1;

  rd_state_e          state_q, state_d;
  cnt_t               rd_cnt_q, rd_cnt_d;
  logic               wsel_q, wsel_d;
  logic               ovf_q, ovf_d;
  logic               en_out_q;
  cnt_t               cnt_out_q;
  logic               done;
  logic               last_rd;
  logic               ram_we;
  logic               ram_re;
  logic [N:0]         ram_waddr;
  logic [N:0]         ram_raddr;
  logic [2*width-1:0] ram_rdata;

  assign done    = bus.en_in && (bus.cnt_in == CntLast);
  assign last_rd = (rd_cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q   <= StIdle;
      rd_cnt_q  <= '0;
      wsel_q    <= 1'b0;
      ovf_q     <= 1'b0;
      en_out_q  <= 1'b0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wsel_q    <= wsel_d;
      ovf_q     <= ovf_d;
      en_out_q  <= ram_re;
      cnt_out_q <= rd_cnt_q;
    end
  end

  // A completion always (re)starts the read on the just-finished bank; it only counts
  // as an overflow if the running read still had words left to issue.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wsel_d   = wsel_q;
    ovf_d    = ovf_q;
    if (done) begin
      state_d  = StRead;
      rd_cnt_d = '0;
      wsel_d   = ~wsel_q;
      if ((state_q == StRead) && !last_rd) ovf_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StRead: begin
          if (last_rd) begin
            state_d  = StIdle;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // The read bank is always the one not being written: the last completed bank.
  always_comb begin
    ram_we    = bus.en_in;
    ram_waddr = {wsel_q, cnt_t'(bitrev(32'(bus.cnt_in), N))};
    ram_re    = (state_q == StRead);
    ram_raddr = {~wsel_q, rd_cnt_q};
  end

  reorder_ram #(
    .AddrW(N + 1),
    .DataW(2 * width)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata({bus.xin_re, bus.xin_im}),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign bus.en_out  = en_out_q;
  assign bus.cnt_out = en_out_q ? cnt_out_q : '0;
  assign bus.yout_re = en_out_q ? ram_rdata[2*width-1:width] : '0;
  assign bus.yout_im = en_out_q ? ram_rdata[width-1:0] : '0;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed/random bench for fft_reorder (N=3, width=16) against a bank-and-schedule
// reference model built from the frame, latency and overflow rules.
module tb_fft_reorder;

  localparam int unsigned W       = 16;
  localparam int unsigned NB      = 3;
  localparam int          Pts     = 8;
  localparam int          Horizon = 1024;

  logic clk = 1'b0;
  logic areset;
  logic ovf;

  fft_reorder_if #(.width(W), .N(NB)) bus ();

  fft_reorder #(.width(W), .N(NB)) dut (
    .clk   (clk),
    .areset(areset),
    .bus   (bus),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Model: bank contents indexed by natural cnt_in, plus a per-cycle schedule of the
  // bins that must be on the output.
  logic [31:0] bank_m [2][Pts];
  bit          wsel_m = 1'b0;
  bit          ovf_m  = 1'b0;
  bit          s_valid [Horizon];
  int          s_cnt   [Horizon];
  logic [31:0] s_word  [Horizon];

  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input int cnt,
                      input logic [15:0] re, input logic [15:0] im);
    logic [31:0] w;
    areset     = rst;
    bus.en_in  = en;
    bus.cnt_in = 3'(cnt);
    bus.xin_re = re;
    bus.xin_im = im;
    if (rst) begin
      wsel_m = 1'b0;
      ovf_m  = 1'b0;
      for (int c = cyc_n + 1; c < Horizon; c++) s_valid[c] = 1'b0;
    end else if (en) begin
      bank_m[wsel_m][cnt] = {re, im};
      if (cnt == Pts - 1) begin
        // Bins still pending two cycles out mean the earlier read is cut short.
        if (s_valid[cyc_n + 2]) ovf_m = 1'b1;
        for (int c = cyc_n + 2; c < Horizon; c++) s_valid[c] = 1'b0;
        for (int k = 0; k < Pts; k++) begin
          s_valid[cyc_n + 2 + k] = 1'b1;
          s_cnt[cyc_n + 2 + k]   = k;
          s_word[cyc_n + 2 + k]  = bank_m[wsel_m][rev3(k)];
        end
        wsel_m = !wsel_m;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (s_valid[cyc_n]) begin
      w = s_word[cyc_n];
      chk("en_out", {31'b0, bus.en_out}, 32'd1);
      chk("cnt_out", {29'b0, bus.cnt_out}, 32'(s_cnt[cyc_n]));
      chk("yout_re", {16'b0, bus.yout_re}, {16'b0, w[31:16]});
      chk("yout_im", {16'b0, bus.yout_im}, {16'b0, w[15:0]});
    end else begin
      chk("idle_en_out", {31'b0, bus.en_out}, 32'd0);
      chk("idle_cnt_out", {29'b0, bus.cnt_out}, 32'd0);
      chk("idle_yout_re", {16'b0, bus.yout_re}, 32'd0);
      chk("idle_yout_im", {16'b0, bus.yout_im}, 32'd0);
    end
    chk("ovf", {31'b0, ovf}, {31'b0, ovf_m});
  endtask

  task automatic put(input int cnt, input logic [15:0] re, input logic [15:0] im);
    step(1'b0, 1'b1, cnt, re, im);
  endtask

  // Idle cycles carry junk on cnt_in/xin (including cnt_in=7) to prove en_in gates them.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, int'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
  endtask

  task automatic rand_frame();
    for (int c = 0; c < Pts; c++) put(c, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    areset     = 1'b1;
    bus.en_in  = 1'b0;
    bus.cnt_in = '0;
    bus.xin_re = '0;
    bus.xin_im = '0;

    // Reset state
    step(1'b1, 1'b0, 0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 0, 16'h0, 16'h0);
    idle(2);

    // Contiguous frame with xin_re = cnt_in: yout_re comes out 0,4,2,6,1,5,3,7
    for (int c = 0; c < Pts; c++) put(c, 16'(c), 16'($urandom));
    idle(12);

    // Same frame with en_in low on alternate cycles
    for (int c = 0; c < Pts; c++) begin
      put(c, 16'(c), 16'($urandom));
      idle(1);
    end
    idle(12);

    // Back-to-back frames, second with xin_im = 0x100 + cnt
    rand_frame();
    for (int c = 0; c < Pts; c++) put(c, 16'($urandom), 16'(16'h100 + c));
    idle(20);

    // Restart at cnt_in=0 after 5 samples, then a full frame
    for (int c = 0; c < 5; c++) put(c, 16'($urandom), 16'($urandom));
    rand_frame();
    idle(12);

    // Completion while the read is at rd_cnt=3: overflow and restart
    rand_frame();
    put(0, 16'($urandom), 16'($urandom));
    put(1, 16'($urandom), 16'($urandom));
    put(2, 16'($urandom), 16'($urandom));
    put(7, 16'($urandom), 16'($urandom));
    idle(12);

    // Reset while cnt_out=4 is on the output, then a fresh frame
    rand_frame();
    idle(5);
    step(1'b1, 1'b0, 0, 16'h0, 16'h0);
    idle(3);
    rand_frame();
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
